// File: rtl/mvs_cart_pkg.sv
// Shared types and constants for the banked MVS cartridge controller.
package mvs_cart_pkg;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_WAIT  = 2'd1,
    RD_DRIVE = 2'd2
  } rd_state_t;

  localparam logic [18:0]  BANK_ADDR_DEFAULT = 19'h7FFF8;
  localparam logic [31:0]  FIXED_BASE        = 32'h0000_0000;
  localparam int unsigned  BANK_SHIFT        = 19;

  // Bank 0 of the switchable window sits directly above the fixed 512K-word region.
  function automatic logic [31:0] banked_addr(input logic [7:0] bank, input logic [18:0] addr);
    return ((32'(bank) + 32'd1) << BANK_SHIFT) | 32'(addr);
  endfunction

endpackage

// File: rtl/mvs_pck_latch.sv
// PCK strobe synchroniser and address latch with a ROM-latency fetch token pipe.
module mvs_pck_latch
  import mvs_cart_pkg::*;
#(
  parameter int unsigned DW  = 24,
  parameter int unsigned AW  = 24,
  parameter int unsigned PAD = 3,
  parameter int unsigned LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          strobe,
  input  logic          sub,
  input  logic [DW-1:0] bus,
  output logic [AW-1:0] addr,
  output logic          fire
);

  localparam int unsigned FW = DW + 1 + PAD;

  logic [2:0]    strb_sync;
  logic          sub_q;
  logic [DW-1:0] latch;
  logic [LAT-1:0] tok;

  logic          rise_c;
  logic          issue_c;
  logic [DW-1:0] latch_nx_c;
  logic [FW-1:0] full_c;

  assign rise_c     = strb_sync[1] & ~strb_sync[2];
  assign issue_c    = rise_c | (sub ^ sub_q);
  assign latch_nx_c = rise_c ? bus : latch;
  // {latch, sub, PAD zeros}
  assign full_c     = (FW'(latch_nx_c) << (PAD + 1)) | (FW'(sub) << PAD);
  assign fire       = tok[LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strb_sync <= '0;
      sub_q     <= 1'b0;
      latch     <= '0;
      addr      <= '0;
      tok       <= '0;
    end else begin
      strb_sync <= {strb_sync[1:0], strobe};
      sub_q     <= sub;
      latch     <= latch_nx_c;
      addr      <= AW'(full_c);
      tok       <= (tok << 1) | LAT'(issue_c);
    end
  end

endmodule

// File: rtl/mvs_cart_banked.sv
// MVS cartridge controller: C/S video fetch plus fixed and bank-switched 68k P-ROM reads.
module mvs_cart_banked
  import mvs_cart_pkg::*;
#(
  parameter int unsigned PBANKS    = 4,
  parameter int unsigned CROM_AW   = 24,
  parameter int unsigned SROM_AW   = 17,
  parameter int unsigned PROM_AW   = 20,
  parameter int unsigned ROM_LAT   = 2,
  parameter logic [18:0] BANK_ADDR = BANK_ADDR_DEFAULT
) (
  input  logic               CLK_24M,
  input  logic               RESET,
  input  logic [23:0]        PBUS,
  input  logic               CA4,
  input  logic               S2H1,
  input  logic               PCK1B,
  input  logic               PCK2B,
  output logic [31:0]        CR,
  output logic [7:0]         FIXD,
  input  logic [18:0]        M68K_ADDR,
  input  logic [15:0]        M68K_DATA_IN,
  output logic [15:0]        M68K_DATA_OUT,
  output logic               M68K_DATA_OE,
  input  logic               nROMOE,
  input  logic               nPORTOEL,
  input  logic               nPORTOEU,
  input  logic               nPORTWEL,
  output logic [CROM_AW-1:0] CROM_ADDR,
  input  logic [31:0]        CROM_Q,
  output logic [SROM_AW-1:0] SROM_ADDR,
  input  logic [7:0]         SROM_Q,
  output logic [PROM_AW-1:0] PROM_ADDR,
  input  logic [15:0]        PROM_Q,
  output logic [7:0]         BANK
);

  localparam int unsigned CNT_W = 3;

  logic c_fire;
  logic s_fire;

  mvs_pck_latch #(.DW(24), .AW(CROM_AW), .PAD(3), .LAT(ROM_LAT)) u_c_latch (
    .clk    (CLK_24M),
    .rst    (RESET),
    .strobe (PCK1B),
    .sub    (CA4),
    .bus    (PBUS),
    .addr   (CROM_ADDR),
    .fire   (c_fire)
  );

  mvs_pck_latch #(.DW(16), .AW(SROM_AW), .PAD(0), .LAT(ROM_LAT)) u_s_latch (
    .clk    (CLK_24M),
    .rst    (RESET),
    .strobe (PCK2B),
    .sub    (S2H1),
    .bus    (PBUS[15:0]),
    .addr   (SROM_ADDR),
    .fire   (s_fire)
  );

  // Synchronised strobes, bit order {nPORTOEU, nPORTOEL, nROMOE, nPORTWEL}
  logic [3:0]       m_s1;
  logic [3:0]       m_s2;
  logic             we_prev;
  logic [18:0]      addr_q;
  rd_state_t        rd_state;
  logic [CNT_W-1:0] rd_cnt;
  logic             bank_rd;
  logic [7:0]       bank_snap;

  logic               rom_rd_c;
  logic               any_rd_c;
  logic               we_fall_c;
  logic               bank_ok_c;
  logic               bank_rd_nx_c;
  logic [PROM_AW-1:0] prom_nx_c;
  logic               unused_c;

  assign rom_rd_c  = ~m_s2[1];
  assign any_rd_c  = rom_rd_c | ~m_s2[2] | ~m_s2[3];
  assign we_fall_c = we_prev & ~m_s2[0];
  assign bank_ok_c = 9'(M68K_DATA_IN[7:0]) < 9'(PBANKS);
  assign unused_c  = ^M68K_DATA_IN[15:8];

  // Fixed ROM reads win over port reads when both are asserted.
  always_comb begin
    prom_nx_c    = PROM_AW'(FIXED_BASE | 32'(M68K_ADDR));
    bank_rd_nx_c = 1'b0;
    if (!rom_rd_c) begin
      prom_nx_c    = PROM_AW'(banked_addr(BANK, M68K_ADDR));
      bank_rd_nx_c = (M68K_ADDR == BANK_ADDR);
    end
  end

  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      m_s1          <= '1;
      m_s2          <= '1;
      we_prev       <= 1'b1;
      addr_q        <= '0;
      BANK          <= '0;
      rd_state      <= RD_IDLE;
      rd_cnt        <= '0;
      bank_rd       <= 1'b0;
      bank_snap     <= '0;
      PROM_ADDR     <= '0;
      M68K_DATA_OUT <= '0;
      M68K_DATA_OE  <= 1'b0;
      CR            <= '0;
      FIXD          <= '0;
    end else begin
      m_s1    <= {nPORTOEU, nPORTOEL, nROMOE, nPORTWEL};
      m_s2    <= m_s1;
      we_prev <= m_s2[0];
      addr_q  <= M68K_ADDR;

      if (c_fire) CR   <= CROM_Q;
      if (s_fire) FIXD <= SROM_Q;

      if (we_fall_c && (M68K_ADDR == BANK_ADDR) && bank_ok_c)
        BANK <= M68K_DATA_IN[7:0];

      case (rd_state)
        RD_IDLE: begin
          if (any_rd_c) begin
            rd_state  <= RD_WAIT;
            rd_cnt    <= '0;
            PROM_ADDR <= prom_nx_c;
            bank_rd   <= bank_rd_nx_c;
            bank_snap <= BANK;
          end
        end
        RD_WAIT: begin
          if (!any_rd_c) begin
            rd_state <= RD_IDLE;
          end else if (rd_cnt == CNT_W'(ROM_LAT - 1)) begin
            rd_state      <= RD_DRIVE;
            M68K_DATA_OE  <= 1'b1;
            M68K_DATA_OUT <= bank_rd ? {8'h00, bank_snap} : PROM_Q;
          end else begin
            rd_cnt <= rd_cnt + CNT_W'(1);
          end
        end
        RD_DRIVE: begin
          if (!any_rd_c) begin
            rd_state     <= RD_IDLE;
            M68K_DATA_OE <= 1'b0;
          end else if (M68K_ADDR != addr_q) begin
            // New address under a held strobe: refetch with a fresh latency window
            rd_state     <= RD_WAIT;
            M68K_DATA_OE <= 1'b0;
            rd_cnt       <= '0;
            PROM_ADDR    <= prom_nx_c;
            bank_rd      <= bank_rd_nx_c;
            bank_snap    <= BANK;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mvs_cart_banked.sv
// Self-checking bench for mvs_cart_banked: vector table, hand sequences and random traffic.
module tb_mvs_cart_banked;

  localparam int unsigned LAT    = 2;
  localparam int unsigned PB     = 4;
  localparam logic [18:0] BANK_A = 19'h7FFF8;

  logic        clk;
  logic        RESET;
  logic [23:0] PBUS;
  logic        CA4, S2H1, PCK1B, PCK2B;
  logic [31:0] CR;
  logic [7:0]  FIXD;
  logic [18:0] M68K_ADDR;
  logic [15:0] M68K_DATA_IN;
  logic [15:0] M68K_DATA_OUT;
  logic        M68K_DATA_OE;
  logic        nROMOE, nPORTOEL, nPORTOEU, nPORTWEL;
  logic [23:0] CROM_ADDR;
  logic [31:0] CROM_Q;
  logic [16:0] SROM_ADDR;
  logic [7:0]  SROM_Q;
  logic [19:0] PROM_ADDR;
  logic [15:0] PROM_Q;
  logic [7:0]  BANK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [23:0] c_lat;
  logic [15:0] s_lat;
  logic        c_vld, s_vld;
  logic [7:0]  bank_m;

  typedef struct {
    logic        ch;
    logic [23:0] bus;
    logic        sub;
    logic [23:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl [6];
  vec_t r;

  mvs_cart_banked #(
    .PBANKS(PB), .CROM_AW(24), .SROM_AW(17), .PROM_AW(20), .ROM_LAT(LAT), .BANK_ADDR(BANK_A)
  ) dut (
    .CLK_24M(clk), .RESET(RESET), .PBUS(PBUS), .CA4(CA4), .S2H1(S2H1),
    .PCK1B(PCK1B), .PCK2B(PCK2B), .CR(CR), .FIXD(FIXD),
    .M68K_ADDR(M68K_ADDR), .M68K_DATA_IN(M68K_DATA_IN),
    .M68K_DATA_OUT(M68K_DATA_OUT), .M68K_DATA_OE(M68K_DATA_OE),
    .nROMOE(nROMOE), .nPORTOEL(nPORTOEL), .nPORTOEU(nPORTOEU), .nPORTWEL(nPORTWEL),
    .CROM_ADDR(CROM_ADDR), .CROM_Q(CROM_Q), .SROM_ADDR(SROM_ADDR), .SROM_Q(SROM_Q),
    .PROM_ADDR(PROM_ADDR), .PROM_Q(PROM_Q), .BANK(BANK)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ROM contents
  function automatic logic [31:0] crom_f(input logic [23:0] a);
    if (a == 24'h123458) return 32'hDEADBEEF;
    return {a, 8'h00} ^ 32'h5A3C_C3A5;
  endfunction
  function automatic logic [7:0] srom_f(input logic [16:0] a);
    return 8'(a) ^ 8'(a >> 9) ^ 8'h3C;
  endfunction
  function automatic logic [15:0] prom_f(input logic [19:0] a);
    return 16'(a) ^ 16'(a >> 4) ^ 16'hA5A5;
  endfunction

  assign CROM_Q = crom_f(CROM_ADDR);
  assign SROM_Q = srom_f(SROM_ADDR);
  assign PROM_Q = prom_f(PROM_ADDR);

  // Address rules as plain arithmetic
  function automatic logic [23:0] c_addr_m(input logic [23:0] bus, input logic sub);
    return 24'((64'(bus) * 64'd16 + (sub ? 64'd8 : 64'd0)) % 64'd16777216);
  endfunction
  function automatic logic [16:0] s_addr_m(input logic [15:0] bus, input logic sub);
    return 17'(32'(bus) * 32'd2 + (sub ? 32'd1 : 32'd0));
  endfunction
  function automatic logic [19:0] banked_m(input logic [7:0] bank, input logic [18:0] a);
    return 20'(((64'(bank) + 64'd1) * 64'd524288 + 64'(a)) % 64'd1048576);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] cur_data(input logic ch);
    return ch ? 32'(FIXD) : CR;
  endfunction

  // Latch one address on the chosen channel and check address and capture timing
  task automatic run_vec(input vec_t v);
    logic [31:0] prev;
    @(posedge clk); #1;
    if (!v.ch) begin
      if (CA4 != v.sub) c_vld = 1'b1;
      CA4 = v.sub;
    end else begin
      if (S2H1 != v.sub) s_vld = 1'b1;
      S2H1 = v.sub;
    end
    repeat (LAT + 4) @(posedge clk);
    if (!v.ch) prev = c_vld ? crom_f(c_addr_m(c_lat, v.sub)) : 32'h0;
    else       prev = s_vld ? 32'(srom_f(s_addr_m(s_lat, v.sub))) : 32'h0;
    @(negedge clk);
    chk(v.ch ? "fixd_settle" : "cr_settle", cur_data(v.ch), prev);
    @(posedge clk); #1;
    PBUS = v.bus;
    if (!v.ch) PCK1B = 1'b1; else PCK2B = 1'b1;
    repeat (3) @(posedge clk); #1;
    PCK1B = 1'b0;
    PCK2B = 1'b0;
    if (!v.ch) begin c_lat = v.bus; c_vld = 1'b1; end
    else       begin s_lat = v.bus[15:0]; s_vld = 1'b1; end
    @(negedge clk);
    chk(v.ch ? "srom_addr" : "crom_addr", v.ch ? 32'(SROM_ADDR) : 32'(CROM_ADDR), 32'(v.exp_addr));
    for (int k = 1; k < LAT; k++) begin
      @(posedge clk); @(negedge clk);
      chk(v.ch ? "fixd_hold" : "cr_hold", cur_data(v.ch), prev);
    end
    @(posedge clk); @(negedge clk);
    chk(v.ch ? "fixd_cap" : "cr_cap", cur_data(v.ch), v.exp_data);
  endtask

  task automatic wr(input logic [7:0] d);
    @(posedge clk); #1;
    M68K_ADDR    = BANK_A;
    M68K_DATA_IN = {8'hA5, d};
    nPORTWEL     = 1'b0;
    repeat (2) @(posedge clk); @(negedge clk);
    chk("bank_pre", 32'(BANK), 32'(bank_m));
    if (32'(d) < PB) bank_m = d;
    @(posedge clk); @(negedge clk);
    chk("bank_wr", 32'(BANK), 32'(bank_m));
    @(posedge clk); #1;
    nPORTWEL = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  // kind: 0 fixed ROM, 1 port lower, 2 fixed+port together, 3 port upper
  task automatic rd(input int kind, input logic [18:0] a);
    logic [19:0] ea;
    logic [15:0] ed;
    logic        rom, brd;
    rom = (kind == 0) || (kind == 2);
    brd = !rom && (a == BANK_A);
    ea  = rom ? 20'(a) : banked_m(bank_m, a);
    ed  = brd ? {8'h00, bank_m} : prom_f(ea);
    @(posedge clk); #1;
    M68K_ADDR = a;
    nROMOE    = !rom;
    nPORTOEL  = !((kind == 1) || (kind == 2));
    nPORTOEU  = !(kind == 3);
    repeat (2 + LAT) @(posedge clk); @(negedge clk);
    chk("oe_early", 32'(M68K_DATA_OE), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("oe_on", 32'(M68K_DATA_OE), 32'd1);
    chk("rd_data", 32'(M68K_DATA_OUT), 32'(ed));
    if (!brd) chk("prom_addr", 32'(PROM_ADDR), 32'(ea));
    @(posedge clk); #1;
    nROMOE = 1'b1; nPORTOEL = 1'b1; nPORTOEU = 1'b1;
    repeat (2) @(posedge clk); @(negedge clk);
    chk("oe_hold", 32'(M68K_DATA_OE), 32'd1);
    @(posedge clk); @(negedge clk);
    chk("oe_off", 32'(M68K_DATA_OE), 32'd0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; PBUS = '0; CA4 = 1'b0; S2H1 = 1'b0; PCK1B = 1'b0; PCK2B = 1'b0;
    M68K_ADDR = '0; M68K_DATA_IN = '0;
    nROMOE = 1'b1; nPORTOEL = 1'b1; nPORTOEU = 1'b1; nPORTWEL = 1'b1;
    c_lat = '0; s_lat = '0; c_vld = 1'b0; s_vld = 1'b0; bank_m = '0;

    tbl[0] = '{1'b0, 24'h012345, 1'b1, 24'h123458, 32'hDEADBEEF};
    tbl[1] = '{1'b0, 24'hFFFFFF, 1'b0, c_addr_m(24'hFFFFFF, 1'b0), crom_f(c_addr_m(24'hFFFFFF, 1'b0))};
    tbl[2] = '{1'b0, 24'hA5A5A5, 1'b1, c_addr_m(24'hA5A5A5, 1'b1), crom_f(c_addr_m(24'hA5A5A5, 1'b1))};
    tbl[3] = '{1'b1, 24'h12FFFF, 1'b1, 24'(s_addr_m(16'hFFFF, 1'b1)), 32'(srom_f(s_addr_m(16'hFFFF, 1'b1)))};
    tbl[4] = '{1'b1, 24'h008000, 1'b0, 24'(s_addr_m(16'h8000, 1'b0)), 32'(srom_f(s_addr_m(16'h8000, 1'b0)))};
    tbl[5] = '{1'b1, 24'h0000AB, 1'b0, 24'h000156, 32'(srom_f(17'h00156))};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cr", CR, 32'd0);
    chk("rst_fixd", 32'(FIXD), 32'd0);
    chk("rst_bank", 32'(BANK), 32'd0);
    chk("rst_dout", 32'(M68K_DATA_OUT), 32'd0);
    chk("rst_oe", 32'(M68K_DATA_OE), 32'd0);
    chk("rst_crom", 32'(CROM_ADDR), 32'd0);
    chk("rst_srom", 32'(SROM_ADDR), 32'd0);
    chk("rst_prom", 32'(PROM_ADDR), 32'd0);
    RESET = 1'b0;
    repeat (4) @(posedge clk);

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // S2H1 toggle after latching 00AB gives a second capture from the odd address
    @(posedge clk); #1;
    S2H1 = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("s2h1_addr", 32'(SROM_ADDR), 32'h00157);
    for (int k = 1; k < LAT; k++) begin
      @(posedge clk); @(negedge clk);
      chk("s2h1_hold", 32'(FIXD), 32'(srom_f(17'h00156)));
    end
    @(posedge clk); @(negedge clk);
    chk("s2h1_cap", 32'(FIXD), 32'(srom_f(17'h00157)));

    // Bank switching
    wr(8'h02);
    chk("bank_is_2", 32'(BANK), 32'd2);
    rd(1, 19'h00010);
    wr(8'h07);
    rd(1, BANK_A);
    rd(3, 19'h00010);
    rd(2, 19'h2ABCD);
    rd(0, 19'h7FFFF);

    // Address change while driving restarts the latency window
    @(posedge clk); #1;
    M68K_ADDR = 19'h01234; nROMOE = 1'b0;
    repeat (3 + LAT) @(posedge clk); @(negedge clk);
    chk("chg_oe1", 32'(M68K_DATA_OE), 32'd1);
    chk("chg_d1", 32'(M68K_DATA_OUT), 32'(prom_f(20'h01234)));
    @(posedge clk); #1;
    M68K_ADDR = 19'h04321;
    @(posedge clk); @(negedge clk);
    chk("chg_oe_drop", 32'(M68K_DATA_OE), 32'd0);
    chk("chg_prom", 32'(PROM_ADDR), 32'h04321);
    repeat (LAT - 1) @(posedge clk); @(negedge clk);
    chk("chg_oe_wait", 32'(M68K_DATA_OE), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("chg_oe2", 32'(M68K_DATA_OE), 32'd1);
    chk("chg_d2", 32'(M68K_DATA_OUT), 32'(prom_f(20'h04321)));
    @(posedge clk); #1;
    nROMOE = 1'b1;
    repeat (4) @(posedge clk);

    // Random traffic against the model
    for (int i = 0; i < 8; i++) begin
      r.ch  = 1'($urandom);
      r.bus = 24'($urandom);
      r.sub = 1'($urandom);
      r.exp_addr = r.ch ? 24'(s_addr_m(r.bus[15:0], r.sub)) : c_addr_m(r.bus, r.sub);
      r.exp_data = r.ch ? 32'(srom_f(17'(r.exp_addr))) : crom_f(r.exp_addr);
      run_vec(r);
      wr(8'($urandom_range(0, 7)));
      rd(int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? BANK_A : 19'($urandom));
    end

    // Asynchronous reset while driving
    wr(8'h01);
    run_vec(tbl[2]);
    @(posedge clk); #1;
    M68K_ADDR = 19'h00100; nPORTOEL = 1'b0;
    repeat (3 + LAT) @(posedge clk); @(negedge clk);
    chk("pre_rst_oe", 32'(M68K_DATA_OE), 32'd1);
    #2 RESET = 1'b1;
    #1 chk("rst_async_oe", 32'(M68K_DATA_OE), 32'd0);
    nPORTOEL = 1'b1; CA4 = 1'b0; S2H1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    RESET = 1'b0;
    bank_m = '0; c_lat = '0; s_lat = '0; c_vld = 1'b0; s_vld = 1'b0;
    repeat (LAT + 4) @(posedge clk); @(negedge clk);
    chk("post_rst_bank", 32'(BANK), 32'd0);
    chk("post_rst_cr", CR, 32'd0);
    chk("post_rst_fixd", 32'(FIXD), 32'd0);
    chk("post_rst_oe", 32'(M68K_DATA_OE), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
